id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus operand-forwarding and load-use hazard logic for the 16-bit MIPS core.
//  Captures decoded fields from ID and drives the EX-stage ALU operands (Source1/Source2) and ALU_Ctrl.
//  Selects forwarded EX/MEM or MEM/WB results over stale register-file data.
//  Stalls ID for a load-use hazard; a branch flush turns the captured instruction into a bubble.
// PARAMETERS
//  DATA_W  16  datapath width
//  REG_AW  3   register address width (register 0 reads as zero, never forwarded)
//  CTRL_W  4   ALU control width (0010 add, 0110 sub, 0111 slt)
// PORTS
//  clk           in   1       rising-edge clock
//  rst           in   1       synchronous, active-high reset
//  id_valid      in   1       ID holds a real instruction
//  id_rs/id_rt   in   REG_AW  source register addresses
//  id_rd         in   REG_AW  destination register address
//  id_rs_data    in   DATA_W  register-file read data for rs
//  id_rt_data    in   DATA_W  register-file read data for rt
//  id_imm        in   DATA_W  sign-extended immediate
//  id_use_imm    in   1       src2 = imm (rt still used as store data)
//  id_alu_ctrl   in   CTRL_W  ALU operation
//  id_mem_read   in   1       load
//  id_mem_write  in   1       store
//  id_reg_write  in   1       instruction writes rd
//  flush         in   1       branch taken, squash the instruction in ID
//  exm_reg_write in   1       EX/MEM writes a register
//  exm_rd        in   REG_AW  EX/MEM destination
//  exm_result    in   DATA_W  EX/MEM ALU result
//  mwb_reg_write in   1       MEM/WB writes a register
//  mwb_rd        in   REG_AW  MEM/WB destination
//  mwb_data      in   DATA_W  MEM/WB writeback data
//  id_stall      out  1       hold PC and IF/ID (combinational)
//  ex_valid      out  1       EX holds a real instruction
//  ex_src1       out  DATA_W  to ALU Source1 (combinational, post-forward)
//  ex_src2       out  DATA_W  to ALU Source2 (combinational, post-forward or imm)
//  ex_alu_ctrl   out  CTRL_W  to ALU_Ctrl
//  ex_store_data out  DATA_W  forwarded rt value for stores
//  ex_rd         out  REG_AW  registered destination
//  ex_mem_read, ex_mem_write, ex_reg_write  out  1  registered controls, 0 when !ex_valid
// BEHAVIOUR
//  - Reset: all ID/EX registers 0 (ex_valid=0, ex_alu_ctrl=0000, all controls 0); ex_src1/ex_src2/ex_store_data evaluate to 0.
//  - Latency: 1 cycle. A field on ID at edge N appears on ex_* after edge N.
//  - Per edge, priority: rst > flush > id_stall > load.
//  - flush=1 loads a bubble: ex_valid=0, all fields 0. id_stall is forced to 0 while flush=1.
//  - Load-use: id_stall=1 when ex_valid & ex_mem_read & ex_reg_write & ex_rd!=0 & id_valid
//    & (ex_rd==id_rs | (ex_rd==id_rt & (!id_use_imm | id_mem_write))).
//    The stalled edge loads a bubble. The next cycle re-evaluates with the held ID.
//  - Bubble/invalid ID (id_valid=0): registered controls are 0, ex_valid=0.
//  - Forwarding (EX stage, combinational on registered rs/rt):
//    fwd_rs = (exm_reg_write & exm_rd!=0 & exm_rd==rs) ? exm_result
//           : (mwb_reg_write & mwb_rd!=0 & mwb_rd==rs) ? mwb_data
//           : rs_data.
//    fwd_rt is the same for rt.
//  - EX/MEM has priority over MEM/WB when both match. rs/rt==0 always yields the captured data (0).
//  - ex_src1 = fwd_rs; ex_src2 = use_imm ? imm : fwd_rt; ex_store_data = fwd_rt.
//  - No arithmetic in this block; all widths pass through unchanged.
// CONFIGURATION
//  OPERAND_FWD_EN defined: forwarding as above; only load-use stalls.
//  OPERAND_FWD_EN undefined: ex_src1/ex_src2/ex_store_data use captured register data only.
//    id_stall asserts for any valid RAW match (rd!=0, same rs/rt-use rule as above) against:
//    ID/EX (ex_reg_write & ex_valid), EX/MEM (exm_reg_write) or MEM/WB (mwb_reg_write).
//    Flush still overrides.
// TESTING
//  1. rst=1 for 2 edges with random inputs -> ex_valid=0, all controls 0, ex_src1=ex_src2=0.
//  2. ID: add rd=2, rs=1 (0x0005), rt=3 (0x0003), no hazards -> next cycle ex_src1=5, ex_src2=3, ex_alu_ctrl=0010, ex_valid=1.
//  3. EX: rs=2; exm_rd=2, exm_result=0x1234; mwb_rd=2, mwb_data=0x0BAD -> ex_src1=0x1234 (EX/MEM wins).
//     Same with rs=0 -> ex_src1=0.
//  4. Load r4 in EX, then ID: sub rs=4 -> id_stall=1 for exactly 1 cycle, then bubble (ex_valid=0); sub enters the cycle after.
//  5. flush=1 together with load-use condition -> id_stall=0, ex_valid=0, ex_reg_write=0 next cycle.
//  6. OPERAND_FWD_EN undefined: add r5; then ID reads r5 -> id_stall held while r5 is in ID/EX, EX/MEM and MEM/WB (3 cycles),
//     then ex_src1 = regfile value.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and hazard stall for the 16-bit MIPS core.
// Build option OPERAND_FWD_EN: forward EX/MEM and MEM/WB results; otherwise stall on every pending RAW.
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic [CTRL_W-1:0] id_alu_ctrl,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_reg_write,
    input  logic              flush,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_reg_write,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic [DATA_W-1:0] mwb_data,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_src1,
    output logic [DATA_W-1:0] ex_src2,
    output logic [CTRL_W-1:0] ex_alu_ctrl,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write
);

    logic              valid_q,     valid_d;
    logic [REG_AW-1:0] rs_q,        rs_d;
    logic [REG_AW-1:0] rt_q,        rt_d;
    logic [REG_AW-1:0] rd_q,        rd_d;
    logic [DATA_W-1:0] rs_data_q,   rs_data_d;
    logic [DATA_W-1:0] rt_data_q,   rt_data_d;
    logic [DATA_W-1:0] imm_q,       imm_d;
    logic              use_imm_q,   use_imm_d;
    logic [CTRL_W-1:0] alu_ctrl_q,  alu_ctrl_d;
    logic              mem_read_q,  mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              reg_write_q, reg_write_d;

    logic              id_uses_rt;
    logic              hit_idex;
    logic              raw_stall;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // True when a write to rd is consumed by the instruction in ID; r0 is never a dependency.
    function automatic logic reads_reg(input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] rs,
                                       input logic [REG_AW-1:0] rt,
                                       input logic              uses_rt);
        return (rd != '0) && ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction

    // rt is a real source unless replaced by the immediate; stores still need it as data.
    always_comb begin
        id_uses_rt = !id_use_imm || id_mem_write;
        hit_idex   = valid_q && reg_write_q && reads_reg(rd_q, id_rs, id_rt, id_uses_rt);
`ifdef OPERAND_FWD_EN
        raw_stall  = hit_idex && mem_read_q;
`else
        raw_stall  = hit_idex
                   || (exm_reg_write && reads_reg(exm_rd, id_rs, id_rt, id_uses_rt))
                   || (mwb_reg_write && reads_reg(mwb_rd, id_rs, id_rt, id_uses_rt));
`endif
        id_stall   = id_valid && !flush && raw_stall;
    end

    // Flush, stall and invalid ID all load an all-zero bubble.
    always_comb begin
        valid_d     = 1'b0;
        rs_d        = '0;
        rt_d        = '0;
        rd_d        = '0;
        rs_data_d   = '0;
        rt_data_d   = '0;
        imm_d       = '0;
        use_imm_d   = 1'b0;
        alu_ctrl_d  = '0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        reg_write_d = 1'b0;
        if (id_valid && !flush && !id_stall) begin
            valid_d     = 1'b1;
            rs_d        = id_rs;
            rt_d        = id_rt;
            rd_d        = id_rd;
            rs_data_d   = id_rs_data;
            rt_data_d   = id_rt_data;
            imm_d       = id_imm;
            use_imm_d   = id_use_imm;
            alu_ctrl_d  = id_alu_ctrl;
            mem_read_d  = id_mem_read;
            mem_write_d = id_mem_write;
            reg_write_d = id_reg_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            alu_ctrl_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            alu_ctrl_q  <= alu_ctrl_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            reg_write_q <= reg_write_d;
        end
    end

`ifdef OPERAND_FWD_EN
    // EX/MEM is the younger producer, so it wins over MEM/WB.
    always_comb begin
        fwd_rs = rs_data_q;
        if ((rs_q != '0) && exm_reg_write && (exm_rd == rs_q)) begin
            fwd_rs = exm_result;
        end else if ((rs_q != '0) && mwb_reg_write && (mwb_rd == rs_q)) begin
            fwd_rs = mwb_data;
        end
        fwd_rt = rt_data_q;
        if ((rt_q != '0) && exm_reg_write && (exm_rd == rt_q)) begin
            fwd_rt = exm_result;
        end else if ((rt_q != '0) && mwb_reg_write && (mwb_rd == rt_q)) begin
            fwd_rt = mwb_data;
        end
    end
`else
    // Stalls guarantee the captured register data is already current.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{exm_result, mwb_data, rs_q, rt_q};

    always_comb begin
        fwd_rs = rs_data_q;
        fwd_rt = rt_data_q;
    end
`endif

    assign ex_valid      = valid_q;
    assign ex_src1       = fwd_rs;
    assign ex_src2       = use_imm_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_alu_ctrl   = alu_ctrl_q;
    assign ex_rd         = rd_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_reg_write  = reg_write_q;

endmodule
